race_sequencer: RTL

//  Sequences one typing race: IDLE -> COUNTDOWN -> RACE -> RESULT. Latches the

---
 rtl/race_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/race_sequencer.sv
// Typing-race sequencer: IDLE -> COUNTDOWN -> RACE -> RESULT, with countdown, race timer and scorer gating.
// Optional pause support is built only when RACE_PAUSE_EN is defined.
module race_sequencer #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int COUNTDOWN_S = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        mode,
    input  logic [6:0]  value,
    input  logic        word_done,
    input  logic        pause,
    output logic [1:0]  state,
    output logic [1:0]  cd_sec,
    output logic        count_clr,
    output logic        count_en,
    output logic [14:0] timer,
    output logic [6:0]  words,
    output logic        finish
);

    // state        | meaning
    // ST_IDLE      | waiting for a start with non-zero length
    // ST_COUNTDOWN | pre-race countdown, cd_sec shows seconds left
    // ST_RACE      | scorer enabled, timer running, end conditions watched
    // ST_RESULT    | race over, timer/words frozen until start or abort

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_RACE      = 2'd2,
        ST_RESULT    = 2'd3
    } state_t;

    localparam int TICK_DIV = CLK_HZ / 10;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [14:0] TIMER_MAX = 15'h7fff;
    localparam logic [6:0]  WORDS_MAX = 7'h7f;

    state_t            state_q, state_n;
    logic [PRE_W-1:0]  pre_q, pre_n;
    logic [3:0]        sec_q, sec_n;
    logic [1:0]        cd_q, cd_n;
    logic              clr_q, clr_n;
    logic              en_q, en_n;
    logic [14:0]       timer_q, timer_n;
    logic [6:0]        words_q, words_n;
    logic              finish_q, finish_n;
    logic              mode_q, mode_n;
    logic [6:0]        value_q, value_n;

    logic              tick;
    logic              frozen;
    logic              done;
    logic [14:0]       timer_up;
    logic [6:0]        words_up;
    logic [14:0]       time_target;

`ifdef RACE_PAUSE_EN
    logic              paused_q, paused_n;
`else
    logic              unused_pause;
    assign unused_pause = pause;
`endif

    assign time_target = 15'(value_q) * 15'd10;
    assign tick        = (pre_q == PRE_LAST);

    always_comb begin
        state_n  = state_q;
        pre_n    = pre_q;
        sec_n    = sec_q;
        cd_n     = cd_q;
        clr_n    = 1'b0;
        en_n     = en_q;
        timer_n  = timer_q;
        words_n  = words_q;
        finish_n = 1'b0;
        mode_n   = mode_q;
        value_n  = value_q;
        frozen   = 1'b0;
        done     = 1'b0;
        timer_up = timer_q;
        words_up = words_q;
`ifdef RACE_PAUSE_EN
        paused_n = paused_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start && value != 7'd0) begin
                    state_n = ST_COUNTDOWN;
                    mode_n  = mode;
                    value_n = value;
                    clr_n   = 1'b1;
                    timer_n = '0;
                    words_n = '0;
                    cd_n    = 2'(COUNTDOWN_S);
                    pre_n   = '0;
                    sec_n   = 4'd9;
                end
            end
            ST_COUNTDOWN: begin
                pre_n = tick ? '0 : pre_q + 1'b1;
                if (tick) begin
                    // sec_q is a down-counter of ticks; a second ends on its terminal count
                    if (sec_q == 4'd0) begin
                        sec_n = 4'd9;
                        if (cd_q <= 2'd1) begin
                            state_n = ST_RACE;
                            cd_n    = 2'd0;
                            en_n    = 1'b1;
                            pre_n   = '0;
                        end else begin
                            cd_n = cd_q - 2'd1;
                        end
                    end else begin
                        sec_n = sec_q - 4'd1;
                    end
                end
            end
            ST_RACE: begin
`ifdef RACE_PAUSE_EN
                if (pause) paused_n = !paused_q;
                frozen = paused_q;
`endif
                if (!frozen) begin
                    pre_n = tick ? '0 : pre_q + 1'b1;
                    if (tick && timer_q != TIMER_MAX) timer_up = timer_q + 15'd1;
                    if (word_done && words_q != WORDS_MAX) words_up = words_q + 7'd1;
                    timer_n = timer_up;
                    words_n = words_up;
                    // end test uses the post-update values so a same-cycle word still counts
                    done = (!mode_q && words_up == value_q) ||
                           (mode_q && timer_up == time_target) ||
                           (timer_up == TIMER_MAX);
                end
                en_n = 1'b1;
`ifdef RACE_PAUSE_EN
                en_n = !paused_n;
`endif
                if (done) begin
                    state_n  = ST_RESULT;
                    en_n     = 1'b0;
                    finish_n = 1'b1;
                end
            end
            ST_RESULT: begin
                if (start) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        if (abort) begin
            state_n  = ST_IDLE;
            cd_n     = 2'd0;
            clr_n    = 1'b0;
            en_n     = 1'b0;
            finish_n = 1'b0;
            timer_n  = timer_q;
            words_n  = words_q;
            mode_n   = mode_q;
            value_n  = value_q;
        end

`ifdef RACE_PAUSE_EN
        if (state_n != ST_RACE) paused_n = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pre_q    <= '0;
            sec_q    <= '0;
            cd_q     <= '0;
            clr_q    <= 1'b0;
            en_q     <= 1'b0;
            timer_q  <= '0;
            words_q  <= '0;
            finish_q <= 1'b0;
            mode_q   <= 1'b0;
            value_q  <= '0;
        end else begin
            state_q  <= state_n;
            pre_q    <= pre_n;
            sec_q    <= sec_n;
            cd_q     <= cd_n;
            clr_q    <= clr_n;
            en_q     <= en_n;
            timer_q  <= timer_n;
            words_q  <= words_n;
            finish_q <= finish_n;
            mode_q   <= mode_n;
            value_q  <= value_n;
        end
    end

`ifdef RACE_PAUSE_EN
    always_ff @(posedge clk) begin
        if (rst) paused_q <= 1'b0;
        else     paused_q <= paused_n;
    end
`endif

    assign state     = state_q;
    assign cd_sec    = cd_q;
    assign count_clr = clr_q;
    assign count_en  = en_q;
    assign timer     = timer_q;
    assign words     = words_q;
    assign finish    = finish_q;

endmodule
